// File: rtl/regfile_arb_pkg.sv
// Shared defaults and types for the register-file port arbiter.
package regfile_arb_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 3;
  localparam int NUM_REQ_DEF = 2;

  typedef logic req_idx_t;

  localparam req_idx_t PTR_RST = 1'b0;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with its own priority pointer; grants are
// suppressed while rst is high.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_idx_t   gnt_idx,
  output logic       gnt_any
);

  req_idx_t ptr;

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = PTR_RST;
    gnt_any = 1'b0;
    if (!rst) begin
      if (req == 2'b11)
        gnt_idx = ptr;
      else if (req[1])
        gnt_idx = 1'b1;
      else
        gnt_idx = 1'b0;
      gnt_any = |req;
      if (gnt_any)
        gnt[gnt_idx] = 1'b1;
    end
  end

  // Contested or not, the granted requester drops to lowest priority.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= PTR_RST;
    else if (gnt_any)
      ptr <= ~gnt_idx;
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port and read port 1 between the CPU core (0)
// and the debug/loader unit (1). Optional read-after-write bypass: RF_ARB_BYPASS_EN.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         rf_read_addr,
  input  logic [DATA_W-1:0]         rf_read_data,
  output logic                      rf_write_enable,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data
);

  logic [NUM_REQ-1:0] rd_req, wr_req, rd_gnt, wr_gnt;
  req_idx_t           rd_idx, wr_idx, rsp_tag;
  logic               rd_any, wr_any, rsp_pend;
  logic [ADDR_W-1:0]  rd_addr_sel, wr_addr_sel, last_rd_addr;
  logic [DATA_W-1:0]  wr_data_sel, rsp_src;

  assign rd_req = req_valid & ~req_we;
  assign wr_req = req_valid & req_we;

  rr_arbiter2 u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx),
    .gnt_any (rd_any)
  );

  rr_arbiter2 u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx),
    .gnt_any (wr_any)
  );

  assign req_ready   = rd_gnt | wr_gnt;
  assign rd_addr_sel = req_addr[rd_idx*ADDR_W +: ADDR_W];
  assign wr_addr_sel = req_addr[wr_idx*ADDR_W +: ADDR_W];
  assign wr_data_sel = req_wdata[wr_idx*DATA_W +: DATA_W];

  assign rf_write_enable = wr_any;
  assign rf_write_addr   = wr_any ? wr_addr_sel : '0;
  assign rf_write_data   = wr_any ? wr_data_sel : '0;

  // The register file samples the read address every cycle, so it parks on the last grant.
  assign rf_read_addr = rst ? '0 : (rd_any ? rd_addr_sel : last_rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_addr <= '0;
      rsp_pend     <= 1'b0;
      rsp_tag      <= PTR_RST;
    end else begin
      rsp_pend <= rd_any;
      if (rd_any) begin
        last_rd_addr <= rd_addr_sel;
        rsp_tag      <= rd_idx;
      end
    end
  end

`ifdef RF_ARB_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= rd_any && wr_any && (rd_addr_sel == wr_addr_sel);
      byp_data <= wr_data_sel;
    end
  end

  assign rsp_src = byp_hit ? byp_data : rf_read_data;
`else
  assign rsp_src = rf_read_data;
`endif

  // A response in flight when reset arrives is dropped.
  always_comb begin
    rsp_valid = '0;
    if (rsp_pend && !rst)
      rsp_valid[rsp_tag] = 1'b1;
  end

  assign rsp_data = (rsp_pend && !rst) ? rsp_src : '0;

endmodule
